// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding word fetch with a fixed latency,
// misaligned/out-of-range faulting, held response, flush and a word preload port.
module imem_responder #(
  parameter int                  ARCH_LEN   = 32,
  parameter int                  INST_LEN   = 32,
  parameter int                  MEM_BYTES  = 1024,
  parameter int                  LATENCY    = 2,
  parameter logic [INST_LEN-1:0] FAULT_INST = 32'h00000013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ARCH_LEN-1:0] req_addr,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [INST_LEN-1:0] resp_inst,
  output logic [1:0]          resp_fault,
  input  logic                flush,
  input  logic                ld_we,
  input  logic [ARCH_LEN-1:0] ld_addr,
  input  logic [INST_LEN-1:0] ld_data
);

  localparam int WORDS = MEM_BYTES / 4;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [ARCH_LEN-1:0] LAST_WORD = ARCH_LEN'(MEM_BYTES - 4);
  localparam logic [ARCH_LEN-1:0] LAST_BYTE = ARCH_LEN'(MEM_BYTES - 1);
  localparam logic [3:0]          CNT_LOAD  = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] F_OK  = 2'b00;
  localparam logic [1:0] F_MIS = 2'b01;
  localparam logic [1:0] F_OOR = 2'b10;

  logic [INST_LEN-1:0] r_mem [WORDS];
  logic [1:0]          r_state;
  logic [3:0]          r_cnt;
  logic [INST_LEN-1:0] r_inst;
  logic [1:0]          r_fault;

  logic          w_accept;
  logic [1:0]    w_fault;
  logic [WW-1:0] w_rd_idx;
  logic [WW-1:0] w_ld_idx;
  logic          w_ld_ok;

  assign req_ready  = (r_state == S_IDLE) && !ld_we && !flush && !rst;
  assign w_accept   = req_valid && req_ready;
  assign resp_valid = (r_state == S_RESP);
  assign resp_inst  = r_inst;
  assign resp_fault = r_fault;

  assign w_rd_idx = req_addr[WW+1:2];
  assign w_ld_idx = ld_addr[WW+1:2];
  // A word-aligned preload fits iff its last byte is inside the store.
  assign w_ld_ok  = (ld_addr <= LAST_BYTE);

  // NOTE: default assigned first so no path leaves w_fault unassigned (no latch).
  always_comb begin
    w_fault = F_OK;
    if (req_addr[1:0] != 2'b00) begin
      w_fault = F_MIS;
    end else if (req_addr > LAST_WORD) begin
      w_fault = F_OOR;
    end
  end

  // NOTE: the backing store is deliberately not reset so it maps onto plain RAM
  // and boot images survive a reset.
  always_ff @(posedge clk) begin
    if (ld_we && w_ld_ok) begin
      r_mem[w_ld_idx] <= ld_data;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_inst  <= '0;
      r_fault <= F_OK;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_fault <= w_fault;
            r_inst  <= (w_fault == F_OK) ? r_mem[w_rd_idx] : FAULT_INST;
            if (LATENCY == 1) begin
              r_state <= S_RESP;
            end else begin
              r_cnt   <= CNT_LOAD;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: vector table, hand-written flush/reset/stall sequences,
// randomized fetches against a word-array model, and a LATENCY=1 instance.
module tb_imem_responder;

  localparam int          LAT_A = 2;
  localparam int          MEM_B = 1024;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, resp_valid, resp_ready, flush, ld_we;
  logic [31:0] req_addr, resp_inst, ld_addr, ld_data;
  logic [1:0]  resp_fault;

  logic        req_valid_b, req_ready_b, resp_valid_b, resp_ready_b, flush_b, ld_we_b;
  logic [31:0] req_addr_b, resp_inst_b, ld_addr_b, ld_data_b;
  logic [1:0]  resp_fault_b;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [MEM_B/4];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [1:0]  fault;
  } vec_t;
  vec_t vecs [9];

  logic        seen;
  logic [31:0] ra, ei;
  logic [1:0]  ef;
  int          r, k;
  logic [31:0] bdat [2];

  always #5 clk = ~clk;

  imem_responder #(.LATENCY(LAT_A)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_inst(resp_inst), .resp_fault(resp_fault),
    .flush(flush), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  imem_responder #(.LATENCY(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
    .resp_inst(resp_inst_b), .resp_fault(resp_fault_b),
    .flush(flush_b), .ld_we(ld_we_b), .ld_addr(ld_addr_b), .ld_data(ld_data_b)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, exp);
    end
  endtask

  // Reference model: word array, low address bits ignored, writes past the end dropped.
  function automatic void model_ld(input logic [31:0] a, input logic [31:0] d);
    if (a / 4 < MEM_B / 4) mem_m[a / 4] = d;
  endfunction

  function automatic void model_fetch(input logic [31:0] a, output logic [31:0] i,
                                      output logic [1:0] f);
    if (a % 4 != 0) begin
      f = 2'b01; i = NOP;
    end else if (a >= MEM_B) begin
      f = 2'b10; i = NOP;
    end else begin
      f = 2'b00; i = mem_m[a / 4];
    end
  endfunction

  task automatic ld_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_we = 1'b0;
    model_ld(a, d);
  endtask

  // One complete fetch: request, latency, optional stall, handshake, back to idle.
  task automatic fetch(input logic [31:0] a, input logic [31:0] xi, input logic [1:0] xf,
                       input int stall, input bit do_ld, input string nm);
    int          lat;
    logic [31:0] la, ldd;
    la = '0; ldd = '0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; resp_ready = (stall == 0);
    #1 check({nm, "/req_ready"}, req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    if (do_ld) begin
      la  = ($urandom_range(0, 1) == 1) ? a : 32'($urandom_range(0, 255) * 4);
      ldd = $urandom();
      ld_we = 1'b1; ld_addr = la; ld_data = ldd;
    end
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      if (ld_we) begin
        ld_we = 1'b0;
        model_ld(la, ldd);
      end
      lat++;
    end
    ld_we = 1'b0;
    check({nm, "/latency"}, lat, LAT_A);
    check({nm, "/inst"}, resp_inst, xi);
    check({nm, "/fault"}, resp_fault, xf);
    check({nm, "/busy"}, req_ready, 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({nm, "/hold_flags"}, {resp_valid, req_ready}, 2'b10);
      check({nm, "/hold_inst"}, resp_inst, xi);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check({nm, "/done"}, resp_valid, 0);
    #1 check({nm, "/idle_ready"}, req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b1; req_addr = '0; resp_ready = 1'b0; flush = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    req_valid_b = 1'b0; req_addr_b = '0; resp_ready_b = 1'b0; flush_b = 1'b0;
    ld_we_b = 1'b0; ld_addr_b = '0; ld_data_b = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst/req_ready", req_ready, 0);
    check("rst/resp_valid", resp_valid, 0);
    check("rst/resp_inst", resp_inst, 0);
    check("rst/resp_fault", resp_fault, 0);
    rst = 1'b0; req_valid = 1'b0;
    #1 check("rst/release_ready", req_ready, 1);

    // Fill the whole store, then the known boot words; 0x7 lands at 0x4,
    // 0x400 and 0xFFFFFFFC must be dropped rather than alias low words.
    for (int w = 0; w < MEM_B / 4; w++) ld_word(32'(w * 4), $urandom());
    ld_word(32'h0000_0000, 32'h0050_0093);
    ld_word(32'h0000_0007, 32'h0010_0113);
    ld_word(32'h0000_03FC, 32'hCAFE_F00D);
    ld_word(32'h0000_0400, 32'hBAD0_BAD0);
    ld_word(32'hFFFF_FFFC, 32'hBAD1_BAD1);
    mem_m[0]   = 32'h0050_0093;
    mem_m[1]   = 32'h0010_0113;
    mem_m[255] = 32'hCAFE_F00D;

    vecs[0] = '{32'h0000_0000, 32'h0050_0093, 2'b00};
    vecs[1] = '{32'h0000_0004, 32'h0010_0113, 2'b00};
    vecs[2] = '{32'h0000_0002, NOP,           2'b01};
    vecs[3] = '{32'h0000_0400, NOP,           2'b10};
    vecs[4] = '{32'h0000_03FD, NOP,           2'b01};
    vecs[5] = '{32'h0000_03FC, 32'hCAFE_F00D, 2'b00};
    vecs[6] = '{32'hFFFF_FFFC, NOP,           2'b10};
    vecs[7] = '{32'h0000_0404, NOP,           2'b10};
    vecs[8] = '{32'h0000_0001, NOP,           2'b01};
    for (int i = 0; i < 9; i++)
      fetch(vecs[i].addr, vecs[i].inst, vecs[i].fault, 0, 1'b0, $sformatf("vec%0d", i));

    // Fetch stall: response held for 5 extra cycles
    fetch(32'h4, 32'h0010_0113, 2'b00, 5, 1'b0, "stall");

    // Flush one cycle after acceptance
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0; resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    #1 check("flush_wait/ready_low", req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    #1 check("flush_wait/no_resp", resp_valid, 0);
    check("flush_wait/ready", req_ready, 1);
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    check("flush_wait/never_valid", seen, 0);
    fetch(32'h4, 32'h0010_0113, 2'b00, 0, 1'b0, "post_flush");

    // Flush coinciding with a request in IDLE
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0; flush = 1'b1;
    #1 check("flush_idle/ready_low", req_ready, 0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    check("flush_idle/not_accepted", seen, 0);

    // Flush overriding a handshake in RESP
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("flush_resp/pre", resp_valid, 1);
    flush = 1'b1; resp_ready = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    #1 check("flush_resp/dropped", resp_valid, 0);
    check("flush_resp/ready", req_ready, 1);
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    check("flush_resp/no_new", seen, 0);

    // Asynchronous reset mid-WAIT
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0; resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #1 rst = 1'b1;
    #1 check("rst_wait/ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    check("rst_wait/lost", seen, 0);

    // Asynchronous reset mid-RESP, no clock edge in between
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h4; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1 check("rst_resp/pre", resp_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_resp/valid", resp_valid, 0);
    check("rst_resp/inst", resp_inst, 0);
    check("rst_resp/fault", resp_fault, 0);
    check("rst_resp/ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0; resp_ready = 1'b1;
    fetch(32'h0, 32'h0050_0093, 2'b00, 0, 1'b0, "after_rst");

    // Randomized fetches with stalls and preload writes while waiting
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      ra = 32'($urandom_range(0, 255) * 4);
      else if (r < 8) ra = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
      else            ra = $urandom() | 32'h0000_0400;
      model_fetch(ra, ei, ef);
      fetch(ra, ei, ef, $urandom_range(0, 3), ($urandom_range(0, 2) == 0),
            $sformatf("rand%0d", it));
    end

    // LATENCY=1 instance: preload blocks acceptance, then back-to-back fetches
    bdat[0] = 32'h1111_1111;
    bdat[1] = 32'h2222_2222;
    @(negedge clk);
    ld_we_b = 1'b1; ld_addr_b = 32'h0; ld_data_b = bdat[0];
    req_valid_b = 1'b1; req_addr_b = 32'h0; resp_ready_b = 1'b1;
    #1 check("b/ld_blocks", req_ready_b, 0);
    @(negedge clk);
    ld_addr_b = 32'h4; ld_data_b = bdat[1];
    #1 check("b/no_accept0", resp_valid_b, 0);
    check("b/ld_blocks2", req_ready_b, 0);
    @(negedge clk);
    ld_we_b = 1'b0;
    #1 check("b/no_accept1", resp_valid_b, 0);
    check("b/ready", req_ready_b, 1);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1 check($sformatf("b/valid%0d", i), resp_valid_b, (i % 2 == 0));
      if (i % 2 == 0) begin
        check($sformatf("b/inst%0d", i), resp_inst_b, bdat[k % 2]);
        check($sformatf("b/fault%0d", i), resp_fault_b, 0);
        k++;
        req_addr_b = (k % 2 == 1) ? 32'h4 : 32'h0;
      end
    end
    req_valid_b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
